// File: rtl/pr_bridge_intc_if.sv
// Bus bundle between the CPU data port, the peripheral devices and the
// interrupt lines of pr_bridge_intc.
interface pr_bridge_intc_if #(
  parameter int NUM_DEV = 6
);
  // CPU side
  logic                    cpu_req;
  logic                    cpu_we;
  logic [31:0]             cpu_addr;
  logic [31:0]             cpu_wd;
  logic [31:0]             cpu_rd;
  logic                    cpu_ack;
  logic                    cpu_err;
  // Peripheral side
  logic [NUM_DEV-1:0]      pr_sel;
  logic                    pr_we;
  logic [31:0]             pr_addr;
  logic [31:0]             pr_wd;
  logic [32*NUM_DEV-1:0]   pr_rd_bus;
  logic [NUM_DEV-1:0]      pr_ack;
  // Interrupts
  logic [NUM_DEV-1:0]      irq_in;
  logic [5:0]              hw_int;

  // Bridge view
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wd, pr_rd_bus, pr_ack, irq_in,
    output cpu_rd, cpu_ack, cpu_err, pr_sel, pr_we, pr_addr, pr_wd, hw_int
  );

  // CPU / device-model view
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wd, pr_rd_bus, pr_ack, irq_in,
    input  cpu_rd, cpu_ack, cpu_err, pr_sel, pr_we, pr_addr, pr_wd, hw_int
  );
endinterface

// File: rtl/pr_bridge_intc.sv
// Peripheral bridge: decodes a 256-byte window into 16-byte device slots,
// runs each device access through a req/ack handshake with a wait timeout,
// and hosts a small interrupt controller in slot 15 that folds per-device
// interrupts onto the six CP0 hardware-interrupt lines.
module pr_bridge_intc #(
  parameter int          NUM_DEV   = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          TIMEOUT   = 15
) (
  input logic clk,
  input logic sys_rstn,
  pr_bridge_intc_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured access
  logic [31:0]        r_addr;
  logic [31:0]        r_wd;
  logic               r_we;
  logic [7:0]         r_wait;
  logic [31:0]        r_rd;
  logic               r_err;

  // Interrupt controller state
  logic [NUM_DEV-1:0] r_mask;
  logic [NUM_DEV-1:0] r_mode;
  logic [NUM_DEV-1:0] r_pend;
  logic [NUM_DEV-1:0] r_prev;
  logic [5:0]         r_hw_int;

  // Decode of the live CPU address (only meaningful in IDLE)
  logic               w_hit;
  logic               w_dev_hit;
  logic               w_ctrl_hit;
  logic               w_accept;
  logic               w_ctrl_wr;
  logic [31:0]        w_reg_rd;

  // Device-side selection from the captured address
  logic [NUM_DEV-1:0] w_sel;
  logic [31:0]        w_slice [NUM_DEV];
  logic [31:0]        w_dev_rd;
  logic               w_dev_ack;
  logic               w_timeout;

  // Interrupt datapath
  logic [NUM_DEV-1:0] w_act;
  logic [NUM_DEV-1:0] w_w1c;
  logic [NUM_DEV-1:0] w_pend_next;
  logic [5:0]         w_hw;
  logic               w_any;
  logic [3:0]         w_low;

  assign w_hit      = (bus.cpu_addr[31:8] == BASE_ADDR[31:8]);
  assign w_dev_hit  = w_hit && (bus.cpu_addr[7:4] < 4'(NUM_DEV));
  assign w_ctrl_hit = w_hit && (bus.cpu_addr[7:4] == 4'hF);
  assign w_accept   = (r_state == S_IDLE) && bus.cpu_req;
  assign w_ctrl_wr  = w_accept && w_ctrl_hit && bus.cpu_we;

  // One-hot slot select and per-slot read data slices
  genvar gi;
  generate
    for (gi = 0; gi < NUM_DEV; gi++) begin : g_dev
      assign w_sel[gi]   = (r_addr[7:4] == 4'(gi));
      assign w_slice[gi] = bus.pr_rd_bus[32*gi +: 32];
    end
  endgenerate

  // Read data of the selected device; other slots' acks are masked off
  always_comb begin
    w_dev_rd = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      if (w_sel[i]) w_dev_rd = w_slice[i];
    end
  end

  assign w_dev_ack = |(w_sel & bus.pr_ack);
  assign w_timeout = (r_wait == 8'(TIMEOUT - 1));

  // Next-state logic of the access sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:   if (bus.cpu_req) w_state_next = w_dev_hit ? S_ACCESS : S_RESP;
      S_ACCESS: if (w_dev_ack || w_timeout) w_state_next = S_RESP;
      S_RESP:   w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!sys_rstn) r_state <= S_IDLE;
    else           r_state <= w_state_next;
  end

  // Access capture, wait counter and response data
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      r_addr <= '0;
      r_wd   <= '0;
      r_we   <= 1'b0;
      r_wait <= '0;
      r_rd   <= '0;
      r_err  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.cpu_req) begin
            r_addr <= bus.cpu_addr;
            r_wd   <= bus.cpu_wd;
            r_we   <= bus.cpu_we;
            r_wait <= '0;
            r_err  <= !(w_dev_hit || w_ctrl_hit);
            r_rd   <= (w_ctrl_hit && !bus.cpu_we) ? w_reg_rd : 32'h0;
          end
        end
        S_ACCESS: begin
          r_wait <= r_wait + 8'd1;
          if (w_dev_ack) begin
            r_rd  <= w_dev_rd;
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_rd  <= '0;
            r_err <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Active (pending and unmasked) sources, lowest-index priority and CP0 fold
  assign w_act = r_pend & r_mask;
  assign w_any = |w_act;

  always_comb begin
    w_low = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      if (w_act[i]) w_low = 4'(i);
    end
  end

  always_comb begin
    w_hw = '0;
    for (int i = 0; i < NUM_DEV; i++) begin
      w_hw[i % 6] = w_hw[i % 6] | w_act[i];
    end
  end

  // Controller register read mux
  always_comb begin
    w_reg_rd = '0;
    case (bus.cpu_addr[3:0])
      4'h0:    w_reg_rd = 32'(r_mask);
      4'h4:    w_reg_rd = 32'(r_pend);
      4'h8:    w_reg_rd = 32'(r_mode);
      4'hC:    w_reg_rd = {w_any, 27'h0, w_low};
      default: w_reg_rd = '0;
    endcase
  end

  // Edge bits: a new rising edge wins over a same-cycle clear; level bits track irq_in
  assign w_w1c = (w_ctrl_wr && bus.cpu_addr[3:0] == 4'h4) ? bus.cpu_wd[NUM_DEV-1:0] : '0;
  assign w_pend_next = (r_mode & ((r_pend & ~w_w1c) | (bus.irq_in & ~r_prev)))
                     | (~r_mode & bus.irq_in);

  // Interrupt controller registers, updated every cycle regardless of the FSM
  always_ff @(posedge clk) begin
    if (!sys_rstn) begin
      r_mask   <= '0;
      r_mode   <= '0;
      r_pend   <= '0;
      r_prev   <= '0;
      r_hw_int <= '0;
    end else begin
      r_prev   <= bus.irq_in;
      r_pend   <= w_pend_next;
      r_hw_int <= w_hw;
      if (w_ctrl_wr && bus.cpu_addr[3:0] == 4'h0) r_mask <= bus.cpu_wd[NUM_DEV-1:0];
      if (w_ctrl_wr && bus.cpu_addr[3:0] == 4'h8) r_mode <= bus.cpu_wd[NUM_DEV-1:0];
    end
  end

  assign bus.cpu_ack = (r_state == S_RESP);
  assign bus.cpu_err = (r_state == S_RESP) && r_err;
  assign bus.cpu_rd  = (r_state == S_RESP) ? r_rd : 32'h0;
  assign bus.pr_sel  = (r_state == S_ACCESS) ? w_sel : '0;
  assign bus.pr_we   = (r_state == S_ACCESS) && r_we;
  assign bus.pr_addr = r_addr;
  assign bus.pr_wd   = r_wd;
  assign bus.hw_int  = r_hw_int;

endmodule

// File: tb/tb_pr_bridge_intc.sv
// Directed bench for pr_bridge_intc: a CPU driver and device responder with a
// scoreboard of expected responses, plus interrupt-path checks.
module tb_pr_bridge_intc;

  localparam int NUM_DEV = 6;

  typedef struct {
    logic [31:0] rd;
    logic        err;
    bit          chk_rd;
    int          lat;
  } exp_t;

  logic clk;
  logic sys_rstn;
  int   checks;
  int   errors;
  exp_t sb[$];

  pr_bridge_intc_if #(.NUM_DEV(NUM_DEV)) bus();

  pr_bridge_intc #(
    .NUM_DEV(NUM_DEV),
    .BASE_ADDR(32'h0000_7F00),
    .TIMEOUT(15)
  ) dut (
    .clk(clk),
    .sys_rstn(sys_rstn),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [NUM_DEV-1:0] sel_of(input logic [31:0] a);
    logic [NUM_DEV-1:0] s;
    s = '0;
    if (a[31:8] == 24'h00007F && a[7:4] < 4'd6) s[a[7:4]] = 1'b1;
    return s;
  endfunction

  // Called just after a negedge; leaves the bench just after a negedge in IDLE.
  // ack_wait < 0 means the addressed device never acknowledges.
  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_err,
                        input bit chk_rd, input int ack_wait, input int exp_lat);
    logic [NUM_DEV-1:0] esel;
    exp_t e;
    int cyc;
    int sel_cnt;
    int slot;
    bit done;
    esel = sel_of(addr);
    slot = int'(addr[7:4]);
    sb.push_back('{rd: exp_rd, err: exp_err, chk_rd: chk_rd, lat: exp_lat});
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = we;
    bus.cpu_addr = addr;
    bus.cpu_wd   = wd;
    cyc = 0;
    sel_cnt = 0;
    done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.pr_ack = '0;
      if (bus.cpu_ack) begin
        done = 1'b1;
        bus.cpu_req = 1'b0;
        e = sb.pop_front();
        check({tag, "/err"}, 32'(bus.cpu_err), 32'(e.err));
        if (e.chk_rd) check({tag, "/rd"}, bus.cpu_rd, e.rd);
        check({tag, "/latency"}, cyc, e.lat);
      end else begin
        check({tag, "/sel"}, 32'(bus.pr_sel), 32'(esel));
        if (esel != '0) begin
          sel_cnt++;
          if (sel_cnt == 1) begin
            check({tag, "/pr_we"}, 32'(bus.pr_we), 32'(we));
            check({tag, "/pr_wd"}, bus.pr_wd, wd);
            check({tag, "/pr_addr"}, bus.pr_addr, addr);
          end
          // Ack from an unrelated slot must be ignored
          bus.pr_ack[(slot + 2) % NUM_DEV] = 1'b1;
          if (ack_wait >= 0 && sel_cnt == ack_wait + 1) bus.pr_ack[slot] = 1'b1;
        end
      end
    end
    if (!done) begin
      check({tag, "/ack_never_came"}, 32'(bus.cpu_ack), 32'h1);
      bus.cpu_req = 1'b0;
      sb.delete();
    end
    @(negedge clk);
    bus.pr_ack = '0;
    check({tag, "/ack_pulse"}, 32'(bus.cpu_ack), 32'h0);
    $display("txn %s we=%0b addr=%h wd=%h rd=%h err=%0b cycles=%0d",
             tag, we, addr, wd, exp_rd, exp_err, cyc);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sys_rstn = 1'b0;
    bus.cpu_req = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = '0;
    bus.cpu_wd = '0;
    bus.pr_ack = '0;
    bus.irq_in = '0;
    for (int i = 0; i < NUM_DEV; i++) bus.pr_rd_bus[32*i +: 32] = 32'hD000_0000 + 32'(i);

    repeat (3) @(negedge clk);
    check("rst/cpu_ack", 32'(bus.cpu_ack), 32'h0);
    check("rst/cpu_err", 32'(bus.cpu_err), 32'h0);
    check("rst/cpu_rd", bus.cpu_rd, 32'h0);
    check("rst/pr_sel", 32'(bus.pr_sel), 32'h0);
    check("rst/pr_we", 32'(bus.pr_we), 32'h0);
    check("rst/pr_addr", bus.pr_addr, 32'h0);
    check("rst/pr_wd", bus.pr_wd, 32'h0);
    check("rst/hw_int", 32'(bus.hw_int), 32'h0);
    sys_rstn = 1'b1;
    @(negedge clk);

    // Controller and device traffic
    access("ihigh_after_reset", 1'b0, 32'h0000_7FFC, 32'h0, 32'h0, 1'b0, 1'b1, -1, 1);
    check("hw_int_idle", 32'(bus.hw_int), 32'h0);
    access("dev1_write_w3", 1'b1, 32'h0000_7F10, 32'hA5A5_0001, 32'h0, 1'b0, 1'b0, 3, 5);
    access("dev3_read_w0", 1'b0, 32'h0000_7F34, 32'h0, 32'hD000_0003, 1'b0, 1'b1, 0, 2);
    access("dev5_read_w1", 1'b0, 32'h0000_7F50, 32'h0, 32'hD000_0005, 1'b0, 1'b1, 1, 3);
    access("dev2_timeout", 1'b0, 32'h0000_7F20, 32'h0, 32'h0, 1'b1, 1'b1, -1, 16);
    access("slot8_unmapped", 1'b0, 32'h0000_7F80, 32'h0, 32'h0, 1'b1, 1'b1, -1, 1);
    access("outside_window", 1'b0, 32'h0000_8000, 32'h0, 32'h0, 1'b1, 1'b1, -1, 1);

    // Edge-mode interrupt on device 0
    access("wr_imode", 1'b1, 32'h0000_7FF8, 32'h0000_0001, 32'h0, 1'b0, 1'b0, -1, 1);
    access("wr_imask", 1'b1, 32'h0000_7FF0, 32'hFFFF_FF21, 32'h0, 1'b0, 1'b0, -1, 1);
    access("rd_imask", 1'b0, 32'h0000_7FF0, 32'h0, 32'h0000_0021, 1'b0, 1'b1, -1, 1);
    bus.irq_in[0] = 1'b1;
    @(negedge clk);
    bus.irq_in[0] = 1'b0;
    check("edge/hw_int_m1", 32'(bus.hw_int), 32'h0);
    @(negedge clk);
    check("edge/hw_int_m2", 32'(bus.hw_int), 32'h01);
    access("edge/rd_ipend", 1'b0, 32'h0000_7FF4, 32'h0, 32'h0000_0001, 1'b0, 1'b1, -1, 1);
    access("edge/rd_ihigh", 1'b0, 32'h0000_7FFC, 32'h0, 32'h8000_0000, 1'b0, 1'b1, -1, 1);
    bus.irq_in[0] = 1'b1;
    access("edge/w1c_vs_set", 1'b1, 32'h0000_7FF4, 32'h0000_0001, 32'h0, 1'b0, 1'b0, -1, 1);
    access("edge/rd_ipend_kept", 1'b0, 32'h0000_7FF4, 32'h0, 32'h0000_0001, 1'b0, 1'b1, -1, 1);
    access("edge/w1c", 1'b1, 32'h0000_7FF4, 32'h0000_0001, 32'h0, 1'b0, 1'b0, -1, 1);
    access("edge/rd_ipend_clr", 1'b0, 32'h0000_7FF4, 32'h0, 32'h0, 1'b0, 1'b1, -1, 1);
    bus.irq_in[0] = 1'b0;

    // Level-mode interrupt on device 5
    access("wr_imode_lvl", 1'b1, 32'h0000_7FF8, 32'h0, 32'h0, 1'b0, 1'b0, -1, 1);
    access("wr_imask_5", 1'b1, 32'h0000_7FF0, 32'h0000_0020, 32'h0, 1'b0, 1'b0, -1, 1);
    bus.irq_in[5] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("lvl/hw_int_on", 32'(bus.hw_int), 32'h20);
    access("lvl/rd_ihigh", 1'b0, 32'h0000_7FFC, 32'h0, 32'h8000_0005, 1'b0, 1'b1, -1, 1);
    access("lvl/w1c", 1'b1, 32'h0000_7FF4, 32'h0000_0020, 32'h0, 1'b0, 1'b0, -1, 1);
    access("lvl/rd_ipend", 1'b0, 32'h0000_7FF4, 32'h0, 32'h0000_0020, 1'b0, 1'b1, -1, 1);
    bus.irq_in[5] = 1'b0;
    @(negedge clk);
    check("lvl/hw_int_m1", 32'(bus.hw_int), 32'h20);
    @(negedge clk);
    check("lvl/hw_int_off", 32'(bus.hw_int), 32'h0);

    // Reset in the middle of a device access aborts it silently
    bus.cpu_req = 1'b1;
    bus.cpu_we = 1'b0;
    bus.cpu_addr = 32'h0000_7F30;
    repeat (3) @(negedge clk);
    check("abort/sel_before", 32'(bus.pr_sel), 32'h08);
    sys_rstn = 1'b0;
    bus.cpu_req = 1'b0;
    @(negedge clk);
    check("abort/sel", 32'(bus.pr_sel), 32'h0);
    check("abort/ack", 32'(bus.cpu_ack), 32'h0);
    sys_rstn = 1'b1;
    @(negedge clk);
    check("abort/ack_after", 32'(bus.cpu_ack), 32'h0);
    access("abort/rd_imask", 1'b0, 32'h0000_7FF0, 32'h0, 32'h0, 1'b0, 1'b1, -1, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
